// File: rtl/focus_pkg.sv
// Shared types, widths and helpers for the focus metric block.
package focus_pkg;

   // Frame tracking states: wait for a clean frame start, idle in vertical blank, accumulate.
   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      VBLANK    = 2'd1,
      ACTIVE    = 2'd2
   } fm_state_t;

   localparam int X_W   = 11;
   localparam int Y_W   = 10;
   localparam int CNT_W = 20;

   // Unsigned add clamped to max_v. Callers zero-extend narrower operands to 32 bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] sum_v;
      sum_v = {1'b0, a} + {1'b0, b};
      if (sum_v > {1'b0, max_v}) begin
         sat_add = max_v;
      end else begin
         sat_add = sum_v[31:0];
      end
   endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Recovers pixel column/row from the blanking and vsync strobes of the VGA stream.
import focus_pkg::*;

module vga_pixel_counter (
   input  logic           VGA_CLK,
   input  logic           reset,
   input  logic           iVGA_VS,
   input  logic           iVGA_BLANK_N,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y
);

   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   logic blank_q_r;

   // Column counts active cycles of the line; row advances at the end of each active line.
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         blank_q_r <= 1'b0;
      end else begin
         blank_q_r <= iVGA_BLANK_N;

         if (!iVGA_BLANK_N) begin
            x <= '0;
         end else if (x != X_MAX) begin
            x <= x + X_W'(1);
         end else begin
            x <= x;
         end

         if (!iVGA_VS) begin
            y <= '0;
         end else if (blank_q_r && !iVGA_BLANK_N && (y != Y_MAX)) begin
            y <= y + Y_W'(1);
         end else begin
            y <= y;
         end
      end
   end

endmodule

// File: rtl/focus_metric.sv
// Per-frame edge-energy sharpness score over a region of interest, with peak hold.
import focus_pkg::*;

module focus_metric #(
   parameter int unsigned WIDTH  = 800,
   parameter int unsigned HEIGHT = 480,
   parameter int unsigned ROI_X0 = 200,
   parameter int unsigned ROI_Y0 = 120,
   parameter int unsigned ROI_W  = 400,
   parameter int unsigned ROI_H  = 240,
   parameter int unsigned THRESH = 16,
   parameter int unsigned ACC_W  = 32
) (
   input  logic             VGA_CLK,
   input  logic             reset,
   input  logic             iVGA_HS,
   input  logic             iVGA_VS,
   input  logic             iVGA_BLANK_N,
   input  logic [7:0]       edge_in,
   input  logic             clear_peak,
   output logic [ACC_W-1:0] oScore,
   output logic [19:0]      oEdge_count,
   output logic             oScore_valid,
   output logic [ACC_W-1:0] oPeak,
   output logic             oImproved
);

   localparam logic [31:0] ACC_MAX = (ACC_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ACC_W) - 32'd1);
   localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

   logic [X_W-1:0]   x_s;
   logic [Y_W-1:0]   y_s;
   fm_state_t        state_r;
   logic             vs_q_r;
   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;

   logic             vs_fall_s;
   logic             in_roi_s;
   logic             qualify_s;
   logic [31:0]      acc_sum_s;
   logic [31:0]      cnt_sum_s;
   logic [ACC_W-1:0] peak_base_s;
   logic             improve_s;
   logic             unused_s;

   vga_pixel_counter u_pos (
      .VGA_CLK      (VGA_CLK),
      .reset        (reset),
      .iVGA_VS      (iVGA_VS),
      .iVGA_BLANK_N (iVGA_BLANK_N),
      .x            (x_s),
      .y            (y_s)
   );

   // hsync only travels alongside the pixel stream; saturated-sum upper bits are don't-care.
   assign unused_s = ^{iVGA_HS, acc_sum_s, cnt_sum_s};

   assign vs_fall_s = vs_q_r & ~iVGA_VS;
   assign acc_sum_s = sat_add(32'(acc_r), 32'(edge_in), ACC_MAX);
   assign cnt_sum_s = sat_add(32'(cnt_r), 32'd1, CNT_MAX);

   // ROI window test, clipped to the active picture, plus the noise-floor threshold.
   always_comb begin
      in_roi_s  = 1'b0;
      qualify_s = 1'b0;
      if ((32'(x_s) >= ROI_X0) && (32'(x_s) < (ROI_X0 + ROI_W)) && (32'(x_s) < WIDTH) &&
          (32'(y_s) >= ROI_Y0) && (32'(y_s) < (ROI_Y0 + ROI_H)) && (32'(y_s) < HEIGHT)) begin
         in_roi_s = 1'b1;
      end else begin
         in_roi_s = 1'b0;
      end
      if ((state_r == ACTIVE) && iVGA_BLANK_N && in_roi_s && (32'(edge_in) >= THRESH)) begin
         qualify_s = 1'b1;
      end else begin
         qualify_s = 1'b0;
      end
   end

   // A clear in the publish cycle takes effect before the improvement compare.
   always_comb begin
      peak_base_s = oPeak;
      if (clear_peak) begin
         peak_base_s = '0;
      end else begin
         peak_base_s = oPeak;
      end
      improve_s = (acc_r > peak_base_s);
   end

   // Frame FSM, accumulators, publish registers and peak hold.
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         state_r      <= SYNC_WAIT;
         vs_q_r       <= 1'b0;
         acc_r        <= '0;
         cnt_r        <= '0;
         oScore       <= '0;
         oEdge_count  <= 20'd0;
         oScore_valid <= 1'b0;
         oPeak        <= '0;
         oImproved    <= 1'b0;
      end else begin
         vs_q_r       <= iVGA_VS;
         oScore_valid <= 1'b0;
         oImproved    <= 1'b0;
         oPeak        <= peak_base_s;

         case (state_r)
            SYNC_WAIT: begin
               acc_r <= '0;
               cnt_r <= '0;
               if (!iVGA_VS) begin
                  state_r <= VBLANK;
               end else begin
                  state_r <= SYNC_WAIT;
               end
            end
            VBLANK: begin
               acc_r <= '0;
               cnt_r <= '0;
               if (iVGA_VS) begin
                  state_r <= ACTIVE;
               end else begin
                  state_r <= VBLANK;
               end
            end
            ACTIVE: begin
               if (vs_fall_s) begin
                  oScore       <= acc_r;
                  oEdge_count  <= cnt_r;
                  oScore_valid <= 1'b1;
                  acc_r        <= '0;
                  cnt_r        <= '0;
                  state_r      <= VBLANK;
                  if (improve_s) begin
                     oPeak     <= acc_r;
                     oImproved <= 1'b1;
                  end else begin
                     oPeak     <= peak_base_s;
                     oImproved <= 1'b0;
                  end
               end else begin
                  state_r <= ACTIVE;
                  if (qualify_s) begin
                     acc_r <= acc_sum_s[ACC_W-1:0];
                     cnt_r <= cnt_sum_s[CNT_W-1:0];
                  end else begin
                     acc_r <= acc_r;
                     cnt_r <= cnt_r;
                  end
               end
            end
            default: begin
               state_r <= SYNC_WAIT;
               acc_r   <= '0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

endmodule
